// File: rtl/riscv_operand_fetch.sv
// Decode / operand-fetch stage: reads the register file, merges writeback bypass data,
// blocks RAW/WAW hazards with a pending scoreboard and registers the issued instruction.
module riscv_operand_fetch #(
  parameter int XLEN          = 32,
  parameter bit ENABLE_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, use_rd, illegal;
  logic [31:0]     pending, pending_next;
  logic            byp_rs1, byp_rs2, byp_rd;
  logic            busy_rs1, busy_rs2, busy_rd;
  logic            hazard, accept;
  logic [XLEN-1:0] op1, op2;

  assign opcode = in_instr[6:0];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: use_rd = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // pending[0] is held at zero, so x0 can never look busy.
  always_comb begin
    byp_rs1  = ENABLE_BYPASS && wb_valid && (wb_rd == rs1);
    byp_rs2  = ENABLE_BYPASS && wb_valid && (wb_rd == rs2);
    byp_rd   = ENABLE_BYPASS && wb_valid && (wb_rd == rd);
    busy_rs1 = pending[rs1] && !byp_rs1;
    busy_rs2 = pending[rs2] && !byp_rs2;
    busy_rd  = pending[rd] && !byp_rd;
    hazard   = in_valid && ((use_rs1 && busy_rs1) || (use_rs2 && busy_rs2) ||
                            (use_rd && busy_rd));
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (use_rs1 && rs1 != 5'd0) op1 = byp_rs1 ? wb_data : rf_rdata1;
    if (use_rs2 && rs2 != 5'd0) op2 = byp_rs2 ? wb_data : rf_rdata2;
  end

  // Set after clear: a register re-issued in the writeback cycle has a new producer in flight.
  always_comb begin
    pending_next = pending;
    if (wb_valid && wb_rd != 5'd0) pending_next[wb_rd] = 1'b0;
    if (accept && use_rd && rd != 5'd0) pending_next[rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_instr    <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_instr    <= in_instr;
      out_rs1_data <= op1;
      out_rs2_data <= op2;
      out_rd       <= use_rd ? rd : 5'd0;
      out_rd_we    <= use_rd && (rd != 5'd0);
      out_illegal  <= illegal;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_operand_fetch.sv
// Directed bench: a bypassing instance driven through a scoreboard of expected issues,
// plus a non-bypassing instance checked for the extra stall cycle.
module tb_riscv_operand_fetch;

  logic        clk;
  logic        reset_n, reset_n_b;

  logic        in_valid, in_ready, wb_valid, out_valid, out_ready, out_rd_we, out_illegal;
  logic [31:0] in_instr, in_pc, rf_rdata1, rf_rdata2, wb_data;
  logic [31:0] out_pc, out_instr, out_rs1_data, out_rs2_data;
  logic [4:0]  rf_rs1, rf_rs2, wb_rd, out_rd;

  logic        in_valid_b, in_ready_b, wb_valid_b, out_valid_b, out_ready_b;
  logic        out_rd_we_b, out_illegal_b;
  logic [31:0] in_instr_b, in_pc_b, rf_rdata1_b, rf_rdata2_b, wb_data_b;
  logic [31:0] out_pc_b, out_instr_b, out_rs1_data_b, out_rs2_data_b;
  logic [4:0]  rf_rs1_b, rf_rs2_b, wb_rd_b, out_rd_b;

  logic [31:0] regs   [32];
  logic [31:0] regs_b [32];

  typedef struct {
    logic [31:0] pc, instr, rs1, rs2;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  exp_t none;
  logic model_ov;
  int   vectors, miscompares;

  riscv_operand_fetch #(.XLEN(32), .ENABLE_BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  riscv_operand_fetch #(.XLEN(32), .ENABLE_BYPASS(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_instr(in_instr_b), .in_pc(in_pc_b), .rf_rs1(rf_rs1_b), .rf_rs2(rf_rs2_b),
    .rf_rdata1(rf_rdata1_b), .rf_rdata2(rf_rdata2_b), .wb_valid(wb_valid_b), .wb_rd(wb_rd_b),
    .wb_data(wb_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b),
    .out_instr(out_instr_b), .out_rs1_data(out_rs1_data_b), .out_rs2_data(out_rs2_data_b),
    .out_rd(out_rd_b), .out_rd_we(out_rd_we_b), .out_illegal(out_illegal_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file models; x0 holds junk so the stage must force x0 operands to zero itself.
  assign rf_rdata1   = regs[rf_rs1];
  assign rf_rdata2   = regs[rf_rs2];
  assign rf_rdata1_b = regs_b[rf_rs1_b];
  assign rf_rdata2_b = regs_b[rf_rs2_b];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'hDEADBEEF : 32'h1000 + i;
    end else if (wb_valid && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always @(posedge clk or negedge reset_n_b) begin
    if (!reset_n_b) begin
      for (int j = 0; j < 32; j++) regs_b[j] <= (j == 0) ? 32'hDEADBEEF : 32'h1000 + j;
    end else if (wb_valid_b && wb_rd_b != 5'd0) begin
      regs_b[wb_rd_b] <= wb_data_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [4:0] rd, input logic we, input logic ill);
    exp_t e;
    e.pc = pc; e.instr = instr; e.rs1 = rs1; e.rs2 = rs2;
    e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic wbv, input logic [4:0] wrd, input logic [31:0] wd,
                               input logic ordy);
    in_valid = v; in_instr = instr; in_pc = pc;
    wb_valid = wbv; wb_rd = wrd; wb_data = wd; out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    check({tag, ".pc"},    out_pc,       e.pc);
    check({tag, ".instr"}, out_instr,    e.instr);
    check({tag, ".rs1"},   out_rs1_data, e.rs1);
    check({tag, ".rs2"},   out_rs2_data, e.rs2);
    check({tag, ".rd"},    out_rd,       e.rd);
    check({tag, ".rd_we"}, out_rd_we,    e.we);
    check({tag, ".ill"},   out_illegal,  e.ill);
  endtask

  // One cycle: check the handshake, queue the expected issue, clock, then compare the slot.
  task automatic step(input string tag, input logic exp_ready, input exp_t rec);
    logic acc;
    check({tag, ".in_ready"}, in_ready, exp_ready);
    acc = in_valid && exp_ready;
    if (acc) sb.push_back(rec);
    model_ov = acc || (model_ov && !out_ready);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".out_valid"}, out_valid, model_ov);
    if (out_valid && sb.size() > 0) held = sb.pop_front();
    if (model_ov) checkOutput(tag, held);
  endtask

  initial begin
    vectors = 0; miscompares = 0; model_ov = 1'b0;
    none = mk(0, 0, 0, 0, 0, 0, 0);
    held = none;
    reset_n = 1'b0; reset_n_b = 1'b0;
    in_valid_b = 0; in_instr_b = 0; in_pc_b = 0; wb_valid_b = 0; wb_rd_b = 0;
    wb_data_b = 0; out_ready_b = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    checkOutput("rst", none);
    reset_n = 1'b1;

    applyStimulus(1, 32'h00500093, 32'h100, 0, 0, 0, 1);
    step("addi_x1", 1, mk(32'h100, 32'h00500093, 0, 0, 5'd1, 1, 0));
    applyStimulus(1, 32'h00108133, 32'h104, 0, 0, 0, 1);
    step("raw_stall1", 0, none);
    step("raw_stall2", 0, none);
    applyStimulus(1, 32'h00108133, 32'h104, 1, 5'd1, 32'd5, 1);
    step("raw_bypass", 1, mk(32'h104, 32'h00108133, 32'd5, 32'd5, 5'd2, 1, 0));

    applyStimulus(1, 32'h00900193, 32'h108, 0, 0, 0, 0);
    step("hold1", 0, none);
    step("hold2", 0, none);
    step("hold3", 0, none);
    applyStimulus(1, 32'h00900193, 32'h108, 0, 0, 0, 1);
    step("hold_release", 1, mk(32'h108, 32'h00900193, 0, 0, 5'd3, 1, 0));

    applyStimulus(1, 32'h00700013, 32'h10C, 0, 0, 0, 1);
    step("addi_x0", 1, mk(32'h10C, 32'h00700013, 0, 0, 5'd0, 0, 0));
    applyStimulus(1, 32'h00000233, 32'h110, 0, 0, 0, 1);
    step("add_x0_src", 1, mk(32'h110, 32'h00000233, 0, 0, 5'd4, 1, 0));

    applyStimulus(0, 32'h0020A023, 32'h114, 1, 5'd3, 32'h33, 1);
    check("idle.rf_rs1", rf_rs1, 5'd1);
    check("idle.rf_rs2", rf_rs2, 5'd2);
    step("idle_wb3", 1, none);
    applyStimulus(0, 32'h0020A023, 32'h114, 1, 5'd4, 32'h44, 1);
    step("idle_wb4", 1, none);
    applyStimulus(1, 32'h0020A023, 32'h114, 0, 0, 0, 1);
    step("sw_stall", 0, none);
    applyStimulus(1, 32'h0020A023, 32'h114, 1, 5'd2, 32'h22, 1);
    step("sw_issue", 1, mk(32'h114, 32'h0020A023, 32'd5, 32'h22, 5'd0, 0, 0));

    applyStimulus(1, 32'h0010800B, 32'h118, 0, 0, 0, 1);
    step("illegal", 1, mk(32'h118, 32'h0010800B, 0, 0, 5'd0, 0, 1));
    applyStimulus(1, 32'h123452B7, 32'h11C, 0, 0, 0, 1);
    step("lui_x5", 1, mk(32'h11C, 32'h123452B7, 0, 0, 5'd5, 1, 0));
    applyStimulus(1, 32'h00100293, 32'h120, 0, 0, 0, 1);
    step("waw_stall", 0, none);
    applyStimulus(1, 32'h00100293, 32'h120, 1, 5'd5, 32'hAA, 1);
    step("waw_issue", 1, mk(32'h120, 32'h00100293, 0, 0, 5'd5, 1, 0));
    applyStimulus(1, 32'h00028333, 32'h124, 0, 0, 0, 1);
    step("set_wins", 0, none);
    applyStimulus(1, 32'h00028333, 32'h124, 1, 5'd5, 32'h55, 1);
    step("x5_bypass", 1, mk(32'h124, 32'h00028333, 32'h55, 0, 5'd6, 1, 0));

    applyStimulus(1, 32'h000303B3, 32'h128, 0, 0, 0, 0);
    step("pre_reset", 0, none);
    reset_n = 1'b0;
    #1;
    model_ov = 1'b0;
    sb.delete();
    check("midrst.out_valid", out_valid, 0);
    checkOutput("midrst", none);
    check("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 32'h000303B3, 32'h128, 0, 0, 0, 1);
    step("post_reset", 1, mk(32'h128, 32'h000303B3, 32'h1006, 0, 5'd7, 1, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    step("drain", 1, none);

    // Non-bypassing instance: the writeback cycle still stalls; issue follows from the RF.
    reset_n_b = 1'b1;
    in_valid_b = 1; in_instr_b = 32'h00500093; in_pc_b = 32'h200;
    #1;
    check("nb.addi.in_ready", in_ready_b, 1);
    @(posedge clk); @(negedge clk);
    check("nb.addi.out_valid", out_valid_b, 1);
    check("nb.addi.rd", out_rd_b, 5'd1);
    check("nb.addi.rd_we", out_rd_we_b, 1);
    check("nb.addi.rs1", out_rs1_data_b, 0);
    in_instr_b = 32'h00108133; in_pc_b = 32'h204;
    wb_valid_b = 1; wb_rd_b = 5'd1; wb_data_b = 32'd5;
    #1;
    check("nb.wb_cycle.in_ready", in_ready_b, 0);
    @(posedge clk); @(negedge clk);
    check("nb.wb_cycle.out_valid", out_valid_b, 0);
    wb_valid_b = 0; wb_rd_b = 0; wb_data_b = 0;
    #1;
    check("nb.after_wb.in_ready", in_ready_b, 1);
    @(posedge clk); @(negedge clk);
    check("nb.add.out_valid", out_valid_b, 1);
    check("nb.add.pc", out_pc_b, 32'h204);
    check("nb.add.instr", out_instr_b, 32'h00108133);
    check("nb.add.rs1", out_rs1_data_b, 32'd5);
    check("nb.add.rs2", out_rs2_data_b, 32'd5);
    check("nb.add.rd", out_rd_b, 5'd2);
    check("nb.add.ill", out_illegal_b, 0);
    in_valid_b = 0;
    @(posedge clk); @(negedge clk);
    check("nb.drain.out_valid", out_valid_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
